mem_port_arbiter: RTL and testbench

- Two-requester controller for the 8-word x 8-bit `mem` block.
- `mem` is asynchronous: RW=0 writes, RW=1 reads.
- The block arbitrates between requesters A and B round-robin, then sequences one access at a time.
- For writes, address and data are settled before RW drops, and RW is low for exactly one clock, so `mem` never sees a spurious write.
- Sits between two clocked client blocks and the unclocked `mem` instance.

---
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port sequencer for an asynchronous RW-strobed memory
module mem_port_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, SETUP, WR, HOLD, RD, DONE} state_t;
    state_t state;
    logic   win;
    logic   we_q;
    logic   last_b;
    logic   gnt_b;
    // B wins only when A is silent or A was served last
    assign gnt_b = b_req & (~a_req | ~last_b);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= 1'b0;
            we_q      <= 1'b0;
            last_b    <= 1'b1;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: if (a_req | b_req) begin
                    win       <= gnt_b;
                    we_q      <= gnt_b ? b_we : a_we;
                    mem_addr  <= gnt_b ? b_addr : a_addr;
                    mem_wdata <= gnt_b ? b_wdata : a_wdata;
                    last_b    <= gnt_b;
                    busy      <= 1'b1;
                    state     <= SETUP;
                end
                SETUP: begin
                    mem_rw <= ~we_q;
                    state  <= we_q ? WR : RD;
                end
                WR: begin
                    mem_rw <= 1'b1;
                    state  <= HOLD;
                end
                HOLD: begin
                    a_ack <= ~win;
                    b_ack <= win;
                    state <= DONE;
                end
                RD: begin
                    rdata <= mem_rdata;
                    a_ack <= ~win;
                    b_ack <= win;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with an ack scoreboard against a behavioural mem
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_ack, b_ack, busy, mem_rw;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [2:0] mem_addr;
    logic [7:0] mem [8];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    typedef struct {bit who; bit rd; logic [7:0] data; int cyc;} exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.AW(3), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .busy(busy), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // mem_rw is registered, so a posedge write while it is low models the async strobe
    always @(posedge clk) if (!mem_rw) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (a_ack || b_ack) begin
            exp_t e;
            chk("ack_exclusive", {31'd0, a_ack & b_ack}, 0);
            if (sb.size() == 0) chk("unexpected_ack", {30'd0, a_ack, b_ack}, 0);
            else begin
                e = sb.pop_front();
                chk("ack_who", {31'd0, b_ack}, {31'd0, e.who});
                chk("ack_cycle", cyc, e.cyc);
                if (e.rd) chk("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_req(input bit who, input bit we, input logic [2:0] addr,
                           input logic [7:0] wd, input bit push, input logic [7:0] exp_rd);
        bit got = 1'b0;
        @(negedge clk);
        if (push) sb.push_back('{who, !we, exp_rd, cyc + (we ? 4 : 3)});
        if (!who) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
        else begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = who ? b_ack : a_ack;
        end
        chk("ack_timeout", {31'd0, got}, 1);
        if (!who) a_req = 1'b0; else b_req = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        do_reset();
        chk("reset_state", {8'd0, mem_rw, a_ack, b_ack, busy, 1'b0, mem_addr, mem_wdata, rdata},
            {8'd0, 4'b1000, 4'd0, 16'd0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_safe", {24'd0, mem_rw, a_ack, b_ack, busy, 1'b0, mem_addr}, 32'h80);
        end
        @(negedge clk);
        sb.push_back('{1'b0, 1'b0, 8'h00, cyc + 4});
        a_we = 1'b1; a_addr = 3'd7; a_wdata = 8'h04; a_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("wrA_addr_data", {21'd0, mem_addr, mem_wdata}, {21'd0, 3'd7, 8'h04});
            chk("wrA_rw_busy", {30'd0, mem_rw, busy}, {30'd0, k != 2, 1'b1});
        end
        a_req = 1'b0;
        chk("wrA_mem7", {24'd0, mem[7]}, 32'h04);
        run_req(1'b0, 1'b1, 3'd3, 8'h02, 1'b1, 8'h00);
        run_req(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'h02);
        repeat (3) @(negedge clk);
        chk("rdata_hold", {24'd0, rdata}, 32'h02);
        do_reset();
        chk("rdata_reset", {24'd0, rdata}, 0);
        @(negedge clk);
        n = cyc + 1;
        sb.push_back('{1'b0, 1'b0, 8'h00, n + 4});
        sb.push_back('{1'b1, 1'b1, 8'h55, n + 8});
        fork
            run_req(1'b0, 1'b1, 3'd3, 8'h55, 1'b0, 8'h00);
            run_req(1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 8'h00);
        join
        @(negedge clk);
        n = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1'b0, 1'b0, 8'h00, n + 9 * i + 4});
            sb.push_back('{1'b1, 1'b1, 8'h10 + 8'(i), n + 9 * i + 8});
        end
        fork
            for (int i = 0; i < 3; i++) run_req(1'b0, 1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 8'h00);
            for (int j = 0; j < 3; j++) run_req(1'b1, 1'b0, 3'(j), 8'h00, 1'b0, 8'h00);
        join
        @(negedge clk);
        a_we = 1'b1; a_addr = 3'd5; a_wdata = 8'hAA; a_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("wr_phase_rw", {31'd0, mem_rw}, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_wr", {28'd0, mem_rw, busy, a_ack, b_ack}, 32'h8);
        rst_n = 1'b1;
        a_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, mem_rw, busy}, 32'h2);
        end
        run_req(1'b0, 1'b1, 3'd5, 8'h0F, 1'b1, 8'h00);
        run_req(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 8'h0F);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
